// File: rtl/qa_writeback_pkg.sv
// Shared package for the Q-learning write-back block (package intellight_pkg).
// Holds the road count and the road field width of an action. It also holds the
// helper functions that derive the level, duration and action widths from
// L_WIDTH, and the FSM state encoding.
package intellight_pkg;

  localparam int N_ROAD       = 4;
  localparam int A_ROAD_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } fsm_state_e;

  // Duration field width inside an action.
  function automatic int d_width(input int l_width);
    return l_width / 2;
  endfunction

  // Q-values per row: one lane per duration code.
  function automatic int n_level(input int l_width);
    return 1 << (l_width / 2);
  endfunction

  // Full action width: {dur, road}.
  function automatic int a_width(input int l_width);
    return A_ROAD_WIDTH + (l_width / 2);
  endfunction

endpackage

// File: rtl/qa_writeback_if.sv
// Update-request interface between the Bellman datapath front end and the
// write-back block.
//   in_valid/in_ready : request handshake, accept when both are high
//   in_state          : Q-table row address
//   in_action         : {dur, road}
//   in_row            : current row Q(S,.) of bank 'road'
//   q_new             : datapath result, valid QA_LAT cycles after accept
// master = request source, slave = qa_writeback.
interface qa_writeback_if #(
  parameter int S_WIDTH   = 8,
  parameter int A_WIDTH   = 4,
  parameter int ROW_WIDTH = 64,
  parameter int Q_WIDTH   = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [S_WIDTH-1:0]   in_state;
  logic [A_WIDTH-1:0]   in_action;
  logic [ROW_WIDTH-1:0] in_row;
  logic [Q_WIDTH-1:0]   q_new;

  modport master (
    output in_valid, in_state, in_action, in_row, q_new,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_state, in_action, in_row, q_new,
    output in_ready
  );
endinterface

// File: rtl/qa_writeback_delay.sv
// qa_wb_delay: valid-tagged shift register that carries each accepted update
// through the datapath latency.
//   clk, rst_n        : clock, synchronous active-low reset (clears all stages)
//   in_*              : entry written into stage 0 every cycle
//   stage_valid/state/road : per-stage tags for the RAW hazard compare
//   out_*             : last stage, i.e. the entry whose q_new is present now
module qa_wb_delay
  import intellight_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int S_WIDTH   = 8,
  parameter int A_WIDTH   = 4,
  parameter int ROW_WIDTH = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [S_WIDTH-1:0]                 in_state,
  input  logic [A_WIDTH-1:0]                 in_action,
  input  logic [ROW_WIDTH-1:0]               in_row,
  output logic [DEPTH-1:0]                   stage_valid,
  output logic [DEPTH-1:0][S_WIDTH-1:0]      stage_state,
  output logic [DEPTH-1:0][A_ROAD_WIDTH-1:0] stage_road,
  output logic                               out_valid,
  output logic [S_WIDTH-1:0]                 out_state,
  output logic [A_WIDTH-1:0]                 out_action,
  output logic [ROW_WIDTH-1:0]               out_row
);

  typedef struct packed {
    logic                 valid;
    logic [S_WIDTH-1:0]   state;
    logic [A_WIDTH-1:0]   action;
    logic [ROW_WIDTH-1:0] row;
  } entry_t;

  entry_t [DEPTH-1:0] entry_q;
  entry_t [DEPTH-1:0] entry_d;

  always_comb begin
    entry_d[0] = '{valid: in_valid, state: in_state, action: in_action, row: in_row};
    for (int i = 1; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
    assign stage_valid[gi] = entry_q[gi].valid;
    assign stage_state[gi] = entry_q[gi].state;
    assign stage_road[gi]  = entry_q[gi].action[A_ROAD_WIDTH-1:0];
  end

  assign out_valid  = entry_q[DEPTH-1].valid;
  assign out_state  = entry_q[DEPTH-1].state;
  assign out_action = entry_q[DEPTH-1].action;
  assign out_row    = entry_q[DEPTH-1].row;

endmodule

// File: rtl/qa_writeback.sv
// qa_writeback: merges Q_new into the stored Q row and writes it back to the
// owning road's Q-table bank. It also runs the zero-fill sweep of all banks.
//   clk, rst_n  : clock, synchronous active-low reset
//   init_start  : pulse, start zero sweep (from IDLE, or from RUN when idle)
//   init_done   : one-cycle pulse after the last sweep write
//   upd         : update request interface (slave side), includes q_new
//   bram_we     : per-road write enable (1111 during sweep, one-hot in RUN)
//   bram_addr   : write address, holds when no write
//   bram_din    : write row, holds when no write
//   busy        : sweep active or any update in flight
//   upd_count   : completed write-backs, wraps
module qa_writeback
  import intellight_pkg::*;
#(
  parameter int  L_WIDTH   = 4,
  parameter int  Q_WIDTH   = 16,
  parameter int  S_WIDTH   = 8,
  parameter int  QA_LAT    = 3,
  localparam int N_LEVEL   = n_level(L_WIDTH),
  localparam int ROW_WIDTH = Q_WIDTH * N_LEVEL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_start,
  output logic                 init_done,
  qa_writeback_if.slave        upd,
  output logic [N_ROAD-1:0]    bram_we,
  output logic [S_WIDTH-1:0]   bram_addr,
  output logic [ROW_WIDTH-1:0] bram_din,
  output logic                 busy,
  output logic [31:0]          upd_count
);

  localparam int D_WIDTH = d_width(L_WIDTH);
  localparam int A_WIDTH = a_width(L_WIDTH);

  fsm_state_e           state_q, state_d;
  logic [N_ROAD-1:0]    bram_we_q, bram_we_d;
  logic [S_WIDTH-1:0]   bram_addr_q, bram_addr_d;
  logic [ROW_WIDTH-1:0] bram_din_q, bram_din_d;
  logic                 init_done_q, init_done_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [31:0]          upd_count_q, upd_count_d;

  // Delay line taps
  logic [QA_LAT-1:0]                   stage_valid;
  logic [QA_LAT-1:0][S_WIDTH-1:0]      stage_state;
  logic [QA_LAT-1:0][A_ROAD_WIDTH-1:0] stage_road;
  logic                                dl_valid;
  logic [S_WIDTH-1:0]                  dl_state;
  logic [A_WIDTH-1:0]                  dl_action;
  logic [ROW_WIDTH-1:0]                dl_row;

  logic [A_ROAD_WIDTH-1:0] in_road;
  logic [QA_LAT-1:0]       stage_hit;
  logic                    wr_hit;
  logic                    hazard;
  logic                    accept;
  logic [D_WIDTH-1:0]      dl_dur;
  logic [A_ROAD_WIDTH-1:0] dl_road;
  logic [ROW_WIDTH-1:0]    merged_row;

  assign in_road = upd.in_action[A_ROAD_WIDTH-1:0];

  // RAW hazard: a request may not read a row whose write-back is still
  // pending anywhere between accept and the bram_we cycle.
  for (genvar gi = 0; gi < QA_LAT; gi++) begin : g_hit
    assign stage_hit[gi] = stage_valid[gi] && (stage_state[gi] == upd.in_state)
                           && (stage_road[gi] == in_road);
  end

  // bram_we_q is one-hot in RUN, so its road bit identifies the bank written.
  assign wr_hit = wr_valid_q && (bram_addr_q == upd.in_state) && bram_we_q[in_road];
  assign hazard = (|stage_hit) || wr_hit;

  assign upd.in_ready = (state_q == RUN) && !hazard;
  assign accept       = upd.in_valid && upd.in_ready;

  qa_wb_delay #(
    .DEPTH     (QA_LAT),
    .S_WIDTH   (S_WIDTH),
    .A_WIDTH   (A_WIDTH),
    .ROW_WIDTH (ROW_WIDTH)
  ) u_delay (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (accept),
    .in_state    (upd.in_state),
    .in_action   (upd.in_action),
    .in_row      (upd.in_row),
    .stage_valid (stage_valid),
    .stage_state (stage_state),
    .stage_road  (stage_road),
    .out_valid   (dl_valid),
    .out_state   (dl_state),
    .out_action  (dl_action),
    .out_row     (dl_row)
  );

  // Merge: replace lane 'dur' of the stored row with q_new.
  assign dl_dur  = dl_action[A_WIDTH-1:A_ROAD_WIDTH];
  assign dl_road = dl_action[A_ROAD_WIDTH-1:0];

  for (genvar gi = 0; gi < N_LEVEL; gi++) begin : g_lane
    assign merged_row[gi*Q_WIDTH +: Q_WIDTH] =
      (dl_dur == D_WIDTH'(gi)) ? upd.q_new : dl_row[gi*Q_WIDTH +: Q_WIDTH];
  end

  assign busy = (state_q == INIT) || (|stage_valid) || wr_valid_q;

  always_comb begin
    state_d     = state_q;
    bram_we_d   = '0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    init_done_d = 1'b0;
    wr_valid_d  = 1'b0;
    upd_count_d = upd_count_q;

    case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d     = INIT;
          bram_we_d   = '1;
          bram_addr_d = '0;
          bram_din_d  = '0;
          upd_count_d = '0;
        end
      end

      INIT: begin
        // bram_addr_q is the address being written this cycle.
        if (bram_addr_q == '1) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          bram_we_d   = '1;
          bram_addr_d = bram_addr_q + S_WIDTH'(1);
        end
      end

      RUN: begin
        if (dl_valid) begin
          wr_valid_d  = 1'b1;
          bram_we_d   = N_ROAD'(1) << dl_road;
          bram_addr_d = dl_state;
          bram_din_d  = merged_row;
          upd_count_d = upd_count_q + 32'd1;
        end
        // A request presented in the same cycle wins over a re-sweep.
        if (init_start && !busy && !upd.in_valid) begin
          state_d     = INIT;
          bram_we_d   = '1;
          bram_addr_d = '0;
          bram_din_d  = '0;
          upd_count_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bram_we_q   <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      init_done_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      upd_count_q <= '0;
    end else begin
      state_q     <= state_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      init_done_q <= init_done_d;
      wr_valid_q  <= wr_valid_d;
      upd_count_q <= upd_count_d;
    end
  end

  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign init_done = init_done_q;
  assign upd_count = upd_count_q;

endmodule

// File: tb/tb_qa_writeback.sv
// Directed bench for qa_writeback (S_WIDTH=3, L_WIDTH=4, Q_WIDTH=16, QA_LAT=3).
module tb_qa_writeback;

  localparam int L_WIDTH   = 4;
  localparam int Q_WIDTH   = 16;
  localparam int S_WIDTH   = 3;
  localparam int QA_LAT    = 3;
  localparam int A_WIDTH   = 4;
  localparam int ROW_WIDTH = 64;
  localparam logic [15:0] QJ = 16'h5A5A;  // junk q_new outside the sample cycle

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_start;
  logic        init_done;
  logic [3:0]  bram_we;
  logic [2:0]  bram_addr;
  logic [63:0] bram_din;
  logic        busy;
  logic [31:0] upd_count;

  int n_checks = 0;
  int n_fail   = 0;

  qa_writeback_if #(.S_WIDTH(S_WIDTH), .A_WIDTH(A_WIDTH), .ROW_WIDTH(ROW_WIDTH),
                    .Q_WIDTH(Q_WIDTH)) upd_if ();

  qa_writeback #(.L_WIDTH(L_WIDTH), .Q_WIDTH(Q_WIDTH), .S_WIDTH(S_WIDTH),
                 .QA_LAT(QA_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (init_start),
    .init_done  (init_done),
    .upd        (upd_if),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .busy       (busy),
    .upd_count  (upd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [3:0]  act;
    logic [63:0] row;
    logic [15:0] qn;
    logic [3:0]  exp_we;
    logic [63:0] exp_din;
  } vec_t;

  typedef struct {
    logic        v;
    logic [2:0]  st;
    logic [3:0]  act;
    logic [63:0] row;
    logic [15:0] qn;
    logic        exp_ready;
    logic [3:0]  exp_we;
    logic [2:0]  exp_addr;
    logic [63:0] exp_din;
    logic [31:0] exp_cnt;
  } cyc_t;

  vec_t vecs[4];
  cyc_t seq[$];

  function automatic logic [63:0] row4(input int a3, input int a2, input int a1, input int a0);
    logic [15:0] l3, l2, l1, l0;
    l3 = 16'(a3); l2 = 16'(a2); l1 = 16'(a1); l0 = 16'(a0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic cyc_t mk(input logic v, input logic [2:0] st, input logic [3:0] act,
                              input logic [63:0] row, input logic [15:0] qn,
                              input logic rdy, input logic [3:0] we, input logic [2:0] addr,
                              input logic [63:0] din, input logic [31:0] cnt);
    cyc_t c;
    c = '{v, st, act, row, qn, rdy, we, addr, din, cnt};
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] a,
                       input logic [63:0] r, input logic [15:0] q);
    upd_if.in_valid  = v;
    upd_if.in_state  = s;
    upd_if.in_action = a;
    upd_if.in_row    = r;
    upd_if.q_new     = q;
  endtask

  // Caller has raised init_start for the current cycle.
  task automatic init_sweep(input string tag);
    next_cycle();
    init_start = 1'b0;
    for (int a = 0; a < 8; a++) begin
      mid();
      chk({tag, " we"},        64'(bram_we),         64'hF);
      chk({tag, " addr"},      64'(bram_addr),       64'(a));
      chk({tag, " din"},       bram_din,             64'h0);
      chk({tag, " busy"},      64'(busy),            64'h1);
      chk({tag, " ready"},     64'(upd_if.in_ready), 64'h0);
      chk({tag, " done_early"}, 64'(init_done),      64'h0);
      if (a == 0) chk({tag, " cnt_cleared"}, 64'(upd_count), 64'h0);
      next_cycle();
    end
    mid();
    chk({tag, " done"},       64'(init_done),       64'h1);
    chk({tag, " we_end"},     64'(bram_we),         64'h0);
    chk({tag, " busy_end"},   64'(busy),            64'h0);
    chk({tag, " ready_run"},  64'(upd_if.in_ready), 64'h1);
    next_cycle();
    mid();
    chk({tag, " done_pulse"}, 64'(init_done),       64'h0);
    $display("%s sweep of 8 addresses complete", tag);
    next_cycle();
  endtask

  task automatic run_seq(input string name);
    for (int c = 0; c < seq.size(); c++) begin
      drive(seq[c].v, seq[c].st, seq[c].act, seq[c].row, seq[c].qn);
      mid();
      if (seq[c].v)
        chk($sformatf("%s c%0d ready", name, c), 64'(upd_if.in_ready), 64'(seq[c].exp_ready));
      chk($sformatf("%s c%0d we", name, c), 64'(bram_we), 64'(seq[c].exp_we));
      if (seq[c].exp_we != 4'd0) begin
        chk($sformatf("%s c%0d addr", name, c), 64'(bram_addr), 64'(seq[c].exp_addr));
        chk($sformatf("%s c%0d din", name, c), bram_din, seq[c].exp_din);
        chk($sformatf("%s c%0d cnt", name, c), 64'(upd_count), 64'(seq[c].exp_cnt));
        $display("%s c%0d write we=%b addr=%0d din=%h cnt=%0d", name, c, bram_we,
                 bram_addr, bram_din, upd_count);
      end
      next_cycle();
    end
    drive(1'b0, 3'd0, 4'd0, 64'd0, QJ);
    seq.delete();
  endtask

  initial begin
    // {state, {dur,road}, row, q_new, expected we, expected merged row}
    vecs[0] = '{3'd5, 4'b1001, row4(40, 30, 20, 10),  16'hFFF9, 4'b0010, row4(40, -7, 20, 10)};
    vecs[1] = '{3'd0, 4'b0000, row4(1, 2, 3, 4),      16'h0064, 4'b0001, row4(1, 2, 3, 100)};
    vecs[2] = '{3'd7, 4'b1111, row4(-1, -2, -3, -4),  16'h7FFF, 4'b1000, row4(32767, -2, -3, -4)};
    vecs[3] = '{3'd2, 4'b0110, row4(5, 6, 7, 8),      16'h8000, 4'b0100, row4(5, 6, -32768, 8)};

    drive(1'b0, 3'd0, 4'd0, 64'd0, QJ);
    rst_n      = 1'b0;
    init_start = 1'b0;
    repeat (3) next_cycle();
    mid();
    chk("rst we",    64'(bram_we),         64'h0);
    chk("rst addr",  64'(bram_addr),       64'h0);
    chk("rst din",   bram_din,             64'h0);
    chk("rst done",  64'(init_done),       64'h0);
    chk("rst ready", 64'(upd_if.in_ready), 64'h0);
    chk("rst cnt",   64'(upd_count),       64'h0);
    chk("rst busy",  64'(busy),            64'h0);
    next_cycle();
    rst_n = 1'b1;

    // Idle without init_start: no sweep, not ready
    mid();
    chk("idle we",    64'(bram_we),         64'h0);
    chk("idle ready", 64'(upd_if.in_ready), 64'h0);
    next_cycle();

    init_start = 1'b1;
    init_sweep("init1");

    // Single updates, one at a time
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vecs[i].st, vecs[i].act, vecs[i].row, QJ);
      mid();
      chk($sformatf("vec%0d ready", i), 64'(upd_if.in_ready), 64'h1);
      next_cycle();
      drive(1'b0, 3'd0, 4'd0, 64'd0, QJ);
      mid();
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'h1);
      next_cycle();
      next_cycle();
      upd_if.q_new = vecs[i].qn;
      mid();
      chk($sformatf("vec%0d we_early", i), 64'(bram_we), 64'h0);
      next_cycle();
      upd_if.q_new = QJ;
      mid();
      chk($sformatf("vec%0d we", i),   64'(bram_we),   64'(vecs[i].exp_we));
      chk($sformatf("vec%0d addr", i), 64'(bram_addr), 64'(vecs[i].st));
      chk($sformatf("vec%0d din", i),  bram_din,       vecs[i].exp_din);
      chk($sformatf("vec%0d cnt", i),  64'(upd_count), 64'(i + 1));
      $display("vec%0d state=%0d action=%b we=%b din=%h cnt=%0d", i, vecs[i].st,
               vecs[i].act, bram_we, bram_din, upd_count);
      next_cycle();
      mid();
      chk($sformatf("vec%0d we_after", i),  64'(bram_we),   64'h0);
      chk($sformatf("vec%0d addr_hold", i), 64'(bram_addr), 64'(vecs[i].st));
      chk($sformatf("vec%0d din_hold", i),  bram_din,       vecs[i].exp_din);
      chk($sformatf("vec%0d busy_end", i),  64'(busy),      64'h0);
      next_cycle();
    end

    // init_start with in_valid (update wins), then init_start while busy (ignored)
    drive(1'b1, 3'd6, 4'b0101, row4(9, 8, 7, 6), QJ);
    init_start = 1'b1;
    mid();
    chk("busyinit accept", 64'(upd_if.in_ready), 64'h1);
    next_cycle();
    drive(1'b0, 3'd0, 4'd0, 64'd0, QJ);
    mid();
    chk("busyinit busy", 64'(busy), 64'h1);
    next_cycle();
    init_start = 1'b0;
    mid();
    chk("busyinit no_sweep", 64'(bram_we), 64'h0);
    next_cycle();
    upd_if.q_new = 16'hFFFD;
    next_cycle();
    upd_if.q_new = QJ;
    mid();
    chk("busyinit we",   64'(bram_we),   64'h2);
    chk("busyinit addr", 64'(bram_addr), 64'h6);
    chk("busyinit din",  bram_din,       row4(9, 8, -3, 6));
    chk("busyinit cnt",  64'(upd_count), 64'h5);
    next_cycle();
    mid();
    chk("busyinit idle", 64'(busy), 64'h0);
    init_start = 1'b1;
    init_sweep("init2");

    // Four distinct accepts back to back
    seq.push_back(mk(1, 3'd3, 4'b1100, row4(11, 12, 13, 14), QJ, 1, 4'h0, 3'd0, 64'd0, 32'd0));
    seq.push_back(mk(1, 3'd4, 4'b0001, row4(21, 22, 23, 24), QJ, 1, 4'h0, 3'd0, 64'd0, 32'd0));
    seq.push_back(mk(1, 3'd6, 4'b1010, row4(31, 32, 33, 34), QJ, 1, 4'h0, 3'd0, 64'd0, 32'd0));
    seq.push_back(mk(1, 3'd0, 4'b0111, row4(41, 42, 43, 44), 16'd101, 1, 4'h0, 3'd0, 64'd0, 32'd0));
    seq.push_back(mk(0, 3'd0, 4'b0000, 64'd0, 16'd102, 0, 4'b0001, 3'd3, row4(101, 12, 13, 14), 32'd1));
    seq.push_back(mk(0, 3'd0, 4'b0000, 64'd0, 16'd103, 0, 4'b0010, 3'd4, row4(21, 22, 23, 102), 32'd2));
    seq.push_back(mk(0, 3'd0, 4'b0000, 64'd0, 16'd104, 0, 4'b0100, 3'd6, row4(31, 103, 33, 34), 32'd3));
    seq.push_back(mk(0, 3'd0, 4'b0000, 64'd0, QJ, 0, 4'b1000, 3'd0, row4(41, 42, 104, 44), 32'd4));
    seq.push_back(mk(0, 3'd0, 4'b0000, 64'd0, QJ, 0, 4'h0, 3'd0, 64'd0, 32'd0));
    run_seq("b2b");

    // RAW hazard: same state, other road passes; same state and road stalls
    seq.push_back(mk(1, 3'd1, 4'b0000, row4(1, 1, 1, 1), QJ, 1, 4'h0, 3'd0, 64'd0, 32'd0));
    seq.push_back(mk(1, 3'd1, 4'b0010, row4(2, 2, 2, 2), QJ, 1, 4'h0, 3'd0, 64'd0, 32'd0));
    seq.push_back(mk(1, 3'd1, 4'b0000, row4(3, 3, 3, 3), QJ, 0, 4'h0, 3'd0, 64'd0, 32'd0));
    seq.push_back(mk(1, 3'd1, 4'b0000, row4(3, 3, 3, 3), 16'd50, 0, 4'h0, 3'd0, 64'd0, 32'd0));
    seq.push_back(mk(1, 3'd1, 4'b0000, row4(3, 3, 3, 3), 16'd60, 0, 4'b0001, 3'd1, row4(1, 1, 1, 50), 32'd5));
    seq.push_back(mk(1, 3'd1, 4'b0000, row4(3, 3, 3, 3), QJ, 1, 4'b0100, 3'd1, row4(2, 2, 2, 60), 32'd6));
    seq.push_back(mk(0, 3'd0, 4'b0000, 64'd0, QJ, 0, 4'h0, 3'd0, 64'd0, 32'd0));
    seq.push_back(mk(0, 3'd0, 4'b0000, 64'd0, QJ, 0, 4'h0, 3'd0, 64'd0, 32'd0));
    seq.push_back(mk(0, 3'd0, 4'b0000, 64'd0, 16'd70, 0, 4'h0, 3'd0, 64'd0, 32'd0));
    seq.push_back(mk(0, 3'd0, 4'b0000, 64'd0, QJ, 0, 4'b0001, 3'd1, row4(3, 3, 3, 70), 32'd7));
    seq.push_back(mk(0, 3'd0, 4'b0000, 64'd0, QJ, 0, 4'h0, 3'd0, 64'd0, 32'd0));
    run_seq("hazard");

    // Reset with two updates in flight: nothing is written afterwards
    drive(1'b1, 3'd1, 4'b0000, row4(7, 7, 7, 7), QJ);
    mid();
    chk("rstmid accept0", 64'(upd_if.in_ready), 64'h1);
    next_cycle();
    drive(1'b1, 3'd2, 4'b0001, row4(8, 8, 8, 8), QJ);
    mid();
    chk("rstmid accept1", 64'(upd_if.in_ready), 64'h1);
    next_cycle();
    drive(1'b0, 3'd0, 4'd0, 64'd0, QJ);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      upd_if.q_new = 16'(c + 200);
      mid();
      chk($sformatf("rstmid c%0d we", c),    64'(bram_we),         64'h0);
      chk($sformatf("rstmid c%0d addr", c),  64'(bram_addr),       64'h0);
      chk($sformatf("rstmid c%0d din", c),   bram_din,             64'h0);
      chk($sformatf("rstmid c%0d cnt", c),   64'(upd_count),       64'h0);
      chk($sformatf("rstmid c%0d busy", c),  64'(busy),            64'h0);
      chk($sformatf("rstmid c%0d ready", c), 64'(upd_if.in_ready), 64'h0);
      chk($sformatf("rstmid c%0d done", c),  64'(init_done),       64'h0);
      next_cycle();
    end
    $display("rstmid in-flight updates discarded");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
